// File: rtl/cluster_bus_isolate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cluster_bus_isolate_ctrl
// Purpose  : Quiesce and throttle controller for one AXI link of the cluster
//            crossbar. Gates new AW/AR requests, counts outstanding write and
//            read transactions, and on request drains the link and reports it
//            isolated so it can be clock-gated, reset or reconfigured. Only the
//            valid/ready/last handshake signals pass through here; the payload
//            buses bypass the block.
// Ports    : clk_i, rst_ni (synchronous, active-low)
//            isolate_req_i                   level drain/isolate request
//            slv_aw_valid_i / slv_aw_ready_o upstream AW handshake
//            mst_aw_valid_o / mst_aw_ready_i downstream AW handshake
//            slv_ar_valid_i / slv_ar_ready_o upstream AR handshake
//            mst_ar_valid_o / mst_ar_ready_i downstream AR handshake
//            mst_b_valid_i, slv_b_ready_i    B handshake (observed only)
//            mst_r_valid_i, slv_r_ready_i,
//            mst_r_last_i                    R handshake (observed only)
//            isolated_o                      link quiescent and gated
//            busy_o                          any transaction outstanding
//            wr_cnt_o, rd_cnt_o              outstanding write/read counts
//            err_o                           sticky response-underflow flag
// Revision : 1.0 - initial release
// ============================================================================
module cluster_bus_isolate_ctrl #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 isolate_req_i,
    // AW channel
    input  logic                 slv_aw_valid_i,
    output logic                 slv_aw_ready_o,
    output logic                 mst_aw_valid_o,
    input  logic                 mst_aw_ready_i,
    // AR channel
    input  logic                 slv_ar_valid_i,
    output logic                 slv_ar_ready_o,
    output logic                 mst_ar_valid_o,
    input  logic                 mst_ar_ready_i,
    // B channel (observed)
    input  logic                 mst_b_valid_i,
    input  logic                 slv_b_ready_i,
    // R channel (observed)
    input  logic                 mst_r_valid_i,
    input  logic                 slv_r_ready_i,
    input  logic                 mst_r_last_i,
    // Status
    output logic                 isolated_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] wr_cnt_o,
    output logic [CNT_WIDTH-1:0] rd_cnt_o,
    output logic                 err_o
);

    localparam logic [CNT_WIDTH-1:0] C_MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] C_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] C_ZERO    = '0;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DRAIN    = 2'd1;
    localparam logic [1:0] S_ISOLATED = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [CNT_WIDTH-1:0] r_wr_cnt;
    logic [CNT_WIDTH-1:0] w_wr_cnt_next;
    logic [CNT_WIDTH-1:0] r_rd_cnt;
    logic [CNT_WIDTH-1:0] w_rd_cnt_next;
    logic                 r_aw_hold;
    logic                 r_ar_hold;
    logic                 r_err;

    logic w_aw_en;
    logic w_ar_en;
    logic w_aw_hs;
    logic w_ar_hs;
    logic w_b_hs;
    logic w_r_last_hs;
    logic w_wr_underflow;
    logic w_rd_underflow;
    logic w_link_empty;

    // ------------------------------------------------------------------------
    // Request gating. A request already presented downstream (hold flag) must
    // stay valid until it handshakes, regardless of state or limit.
    // ------------------------------------------------------------------------
    assign w_aw_en = r_aw_hold | ((r_state == S_IDLE) & (r_wr_cnt < C_MAX_CNT));
    assign w_ar_en = r_ar_hold | ((r_state == S_IDLE) & (r_rd_cnt < C_MAX_CNT));

    assign mst_aw_valid_o = slv_aw_valid_i & w_aw_en;
    assign slv_aw_ready_o = mst_aw_ready_i & w_aw_en;
    assign mst_ar_valid_o = slv_ar_valid_i & w_ar_en;
    assign slv_ar_ready_o = mst_ar_ready_i & w_ar_en;

    assign w_aw_hs     = mst_aw_valid_o & mst_aw_ready_i;
    assign w_ar_hs     = mst_ar_valid_o & mst_ar_ready_i;
    assign w_b_hs      = mst_b_valid_i & slv_b_ready_i;
    assign w_r_last_hs = mst_r_valid_i & slv_r_ready_i & mst_r_last_i;

    // ------------------------------------------------------------------------
    // Outstanding counters. A simultaneous increment and decrement cancels,
    // so no underflow is flagged in that case even from zero.
    // ------------------------------------------------------------------------
    always_comb begin
        w_wr_cnt_next  = r_wr_cnt;
        w_wr_underflow = 1'b0;
        if (w_aw_hs && !w_b_hs) begin
            w_wr_cnt_next = r_wr_cnt + C_ONE;
        end else if (!w_aw_hs && w_b_hs) begin
            if (r_wr_cnt == C_ZERO) begin
                w_wr_underflow = 1'b1;
            end else begin
                w_wr_cnt_next = r_wr_cnt - C_ONE;
            end
        end
    end

    always_comb begin
        w_rd_cnt_next  = r_rd_cnt;
        w_rd_underflow = 1'b0;
        if (w_ar_hs && !w_r_last_hs) begin
            w_rd_cnt_next = r_rd_cnt + C_ONE;
        end else if (!w_ar_hs && w_r_last_hs) begin
            if (r_rd_cnt == C_ZERO) begin
                w_rd_underflow = 1'b1;
            end else begin
                w_rd_cnt_next = r_rd_cnt - C_ONE;
            end
        end
    end

    // Nothing outstanding, nothing pending downstream, nothing starting now.
    assign w_link_empty = (r_wr_cnt == C_ZERO) & (r_rd_cnt == C_ZERO) &
                          ~r_aw_hold & ~r_ar_hold & ~w_aw_hs & ~w_ar_hs;

    // ------------------------------------------------------------------------
    // Isolation state machine
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (isolate_req_i) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!isolate_req_i) begin
                    w_state_next = S_IDLE;
                end else if (w_link_empty) begin
                    w_state_next = S_ISOLATED;
                end
            end
            S_ISOLATED: begin
                // A stray response here only raises err_o; the state holds.
                if (!isolate_req_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_wr_cnt  <= C_ZERO;
            r_rd_cnt  <= C_ZERO;
            r_aw_hold <= 1'b0;
            r_ar_hold <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_wr_cnt  <= w_wr_cnt_next;
            r_rd_cnt  <= w_rd_cnt_next;
            r_aw_hold <= mst_aw_valid_o & ~mst_aw_ready_i;
            r_ar_hold <= mst_ar_valid_o & ~mst_ar_ready_i;
            r_err     <= r_err | w_wr_underflow | w_rd_underflow;
        end
    end

    assign isolated_o = (r_state == S_ISOLATED);
    assign busy_o     = (r_wr_cnt != C_ZERO) | (r_rd_cnt != C_ZERO);
    assign wr_cnt_o   = r_wr_cnt;
    assign rd_cnt_o   = r_rd_cnt;
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cluster_bus_isolate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cluster_bus_isolate_ctrl
// Purpose  : Self-checking bench for cluster_bus_isolate_ctrl. Directed
//            scenarios plus a randomized run against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cluster_bus_isolate_ctrl;

    localparam int MAX = 8;
    localparam int CW  = $clog2(MAX + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          isolate_req_i;
    logic          slv_aw_valid_i, mst_aw_ready_i;
    logic          slv_ar_valid_i, mst_ar_ready_i;
    logic          mst_b_valid_i, slv_b_ready_i;
    logic          mst_r_valid_i, slv_r_ready_i, mst_r_last_i;
    logic          slv_aw_ready_o, mst_aw_valid_o;
    logic          slv_ar_ready_o, mst_ar_valid_o;
    logic          isolated_o, busy_o, err_o;
    logic [CW-1:0] wr_cnt_o, rd_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model: counts of outstanding transactions, a mode
    // (0 pass-through, 1 draining, 2 isolated), pending-downstream flags.
    int m_wr, m_rd, m_mode;
    bit m_err, m_aw_pending, m_ar_pending;

    cluster_bus_isolate_ctrl #(.MAX_OUTSTANDING(MAX)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .isolate_req_i  (isolate_req_i),
        .slv_aw_valid_i (slv_aw_valid_i),
        .slv_aw_ready_o (slv_aw_ready_o),
        .mst_aw_valid_o (mst_aw_valid_o),
        .mst_aw_ready_i (mst_aw_ready_i),
        .slv_ar_valid_i (slv_ar_valid_i),
        .slv_ar_ready_o (slv_ar_ready_o),
        .mst_ar_valid_o (mst_ar_valid_o),
        .mst_ar_ready_i (mst_ar_ready_i),
        .mst_b_valid_i  (mst_b_valid_i),
        .slv_b_ready_i  (slv_b_ready_i),
        .mst_r_valid_i  (mst_r_valid_i),
        .slv_r_ready_i  (slv_r_ready_i),
        .mst_r_last_i   (mst_r_last_i),
        .isolated_o     (isolated_o),
        .busy_o         (busy_o),
        .wr_cnt_o       (wr_cnt_o),
        .rd_cnt_o       (rd_cnt_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit mdl_aw_open();
        return m_aw_pending || (m_mode == 0 && m_wr < MAX);
    endfunction

    function automatic bit mdl_ar_open();
        return m_ar_pending || (m_mode == 0 && m_rd < MAX);
    endfunction

    // Advance one clock and apply the model rules to the inputs seen at it.
    task automatic tick();
        bit aw_open, ar_open, aw_hs, ar_hs, b_hs, r_hs;
        @(posedge clk_i);
        aw_open = mdl_aw_open();
        ar_open = mdl_ar_open();
        aw_hs = slv_aw_valid_i && mst_aw_ready_i && aw_open;
        ar_hs = slv_ar_valid_i && mst_ar_ready_i && ar_open;
        b_hs  = mst_b_valid_i && slv_b_ready_i;
        r_hs  = mst_r_valid_i && slv_r_ready_i && mst_r_last_i;
        if (!rst_ni) begin
            m_wr = 0; m_rd = 0; m_mode = 0; m_err = 0;
            m_aw_pending = 0; m_ar_pending = 0;
        end else begin
            case (m_mode)
                0: if (isolate_req_i) m_mode = 1;
                1: if (!isolate_req_i) m_mode = 0;
                   else if (m_wr == 0 && m_rd == 0 && !m_aw_pending && !m_ar_pending
                            && !aw_hs && !ar_hs) m_mode = 2;
                default: if (!isolate_req_i) m_mode = 0;
            endcase
            m_aw_pending = slv_aw_valid_i && aw_open && !mst_aw_ready_i;
            m_ar_pending = slv_ar_valid_i && ar_open && !mst_ar_ready_i;
            m_wr = m_wr + int'(aw_hs) - int'(b_hs);
            m_rd = m_rd + int'(ar_hs) - int'(r_hs);
            if (m_wr < 0) begin m_wr = 0; m_err = 1; end
            if (m_rd < 0) begin m_rd = 0; m_err = 1; end
        end
        #1;
    endtask

    task automatic quiet_inputs();
        slv_aw_valid_i = 0; mst_aw_ready_i = 1;
        slv_ar_valid_i = 0; mst_ar_ready_i = 1;
        mst_b_valid_i  = 0; slv_b_ready_i  = 1;
        mst_r_valid_i  = 0; slv_r_ready_i  = 1; mst_r_last_i = 0;
    endtask

    task automatic do_reset();
        rst_ni = 0; isolate_req_i = 0; quiet_inputs();
        tick(); tick();
        rst_ni = 1;
    endtask

    task automatic test_reset();
        rst_ni = 0; isolate_req_i = 1; quiet_inputs(); slv_aw_valid_i = 1;
        tick(); tick();
        #2;
        n_checks++;
        if ({isolated_o, busy_o, err_o, wr_cnt_o, rd_cnt_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_status: got iso=%b busy=%b err=%b wr=%0d rd=%0d want all 0",
                     isolated_o, busy_o, err_o, wr_cnt_o, rd_cnt_o);
        end
        n_checks++;
        if (mst_aw_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_passthrough: mst_aw_valid_o got %b want 1", mst_aw_valid_o);
        end
        rst_ni = 1; isolate_req_i = 0; slv_aw_valid_i = 0;
        tick();
    endtask

    task automatic test_throttle();
        int accepted = 0;
        do_reset();
        slv_aw_valid_i = 1;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (slv_aw_ready_o === 1'b1) accepted++;
            n_checks++;
            if (slv_aw_ready_o !== (i < MAX)) begin
                n_errors++;
                $display("FAIL throttle_ready[%0d]: got %b want %b", i, slv_aw_ready_o, i < MAX);
            end
            tick();
        end
        #2;
        n_checks++;
        if (accepted != 8 || wr_cnt_o !== CW'(8) || mst_aw_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL throttle_limit: accepted=%0d wr=%0d mst_valid=%b want 8 8 0",
                     accepted, wr_cnt_o, mst_aw_valid_o);
        end
        slv_aw_valid_i = 0; mst_b_valid_i = 1;
        tick();
        mst_b_valid_i = 0;
        #2;
        n_checks++;
        if (wr_cnt_o !== CW'(7)) begin
            n_errors++;
            $display("FAIL throttle_after_b: wr got %0d want 7", wr_cnt_o);
        end
        slv_aw_valid_i = 1;
        #2;
        n_checks++;
        if (slv_aw_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL throttle_reopen: ready got %b want 1", slv_aw_ready_o);
        end
        tick();
        slv_aw_valid_i = 0;
        #2;
        n_checks++;
        if (wr_cnt_o !== CW'(8)) begin
            n_errors++;
            $display("FAIL throttle_refill: wr got %0d want 8", wr_cnt_o);
        end
    endtask

    task automatic test_drain();
        bit last_pat [5];
        int exp_rd   [5];
        last_pat = '{1, 0, 0, 1, 1};
        exp_rd   = '{2, 2, 2, 1, 0};
        do_reset();
        slv_ar_valid_i = 1;
        tick(); tick(); tick();
        slv_ar_valid_i = 0;
        isolate_req_i  = 1;
        tick();
        slv_ar_valid_i = 1;
        #2;
        n_checks++;
        if (rd_cnt_o !== CW'(3) || mst_ar_valid_o !== 1'b0 || slv_ar_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_block: rd=%0d mst_valid=%b ready=%b want 3 0 0",
                     rd_cnt_o, mst_ar_valid_o, slv_ar_ready_o);
        end
        slv_ar_valid_i = 0;
        for (int k = 0; k < 5; k++) begin
            mst_r_valid_i = 1; mst_r_last_i = last_pat[k];
            tick();
            mst_r_valid_i = 0; mst_r_last_i = 0;
            #2;
            n_checks++;
            if (rd_cnt_o !== CW'(exp_rd[k]) || isolated_o !== 1'b0) begin
                n_errors++;
                $display("FAIL drain_beat[%0d]: rd=%0d iso=%b want %0d 0",
                         k, rd_cnt_o, isolated_o, exp_rd[k]);
            end
        end
        tick();
        #2;
        n_checks++;
        if (isolated_o !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_isolated: iso got %b want 1", isolated_o);
        end
        isolate_req_i = 0;
        tick();
    endtask

    task automatic test_hold();
        do_reset();
        slv_aw_valid_i = 1; mst_aw_ready_i = 0;
        tick();
        isolate_req_i = 1;
        tick();
        #2;
        n_checks++;
        if (mst_aw_valid_o !== 1'b1 || slv_aw_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_kept: mst_valid=%b ready=%b want 1 0", mst_aw_valid_o, slv_aw_ready_o);
        end
        mst_aw_ready_i = 1;
        #2;
        n_checks++;
        if (slv_aw_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_handshake: ready got %b want 1", slv_aw_ready_o);
        end
        tick();
        #2;
        n_checks++;
        if (wr_cnt_o !== CW'(1) || mst_aw_valid_o !== 1'b0 || isolated_o !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_count: wr=%0d mst_valid=%b iso=%b want 1 0 0",
                     wr_cnt_o, mst_aw_valid_o, isolated_o);
        end
        slv_aw_valid_i = 0;
        tick(); tick();
        mst_b_valid_i = 1;
        tick();
        mst_b_valid_i = 0;
        #2;
        n_checks++;
        if (wr_cnt_o !== CW'(0) || isolated_o !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_b: wr=%0d iso=%b want 0 0", wr_cnt_o, isolated_o);
        end
        tick();
        #2;
        n_checks++;
        if (isolated_o !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_isolated: iso got %b want 1", isolated_o);
        end
        isolate_req_i = 0;
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        slv_aw_valid_i = 1;
        tick(); tick();
        mst_b_valid_i = 1;
        tick();
        slv_aw_valid_i = 0; mst_b_valid_i = 0;
        #2;
        n_checks++;
        if (wr_cnt_o !== CW'(2) || err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL simul_aw_b: wr=%0d err=%b want 2 0", wr_cnt_o, err_o);
        end
        do_reset();
        isolate_req_i = 1;
        tick();
        #2;
        n_checks++;
        if (isolated_o !== 1'b0) begin
            n_errors++;
            $display("FAIL simul_latency_n1: iso got %b want 0", isolated_o);
        end
        tick();
        #2;
        n_checks++;
        if (isolated_o !== 1'b1) begin
            n_errors++;
            $display("FAIL simul_latency_n2: iso got %b want 1", isolated_o);
        end
        isolate_req_i = 0;
        tick();
    endtask

    task automatic test_abort_release();
        do_reset();
        isolate_req_i = 1;
        tick();
        slv_aw_valid_i = 1;
        #2;
        n_checks++;
        if (slv_aw_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_blocked: ready got %b want 0", slv_aw_ready_o);
        end
        isolate_req_i = 0;
        tick();
        #2;
        n_checks++;
        if (slv_aw_ready_o !== 1'b1 || isolated_o !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_resume: ready=%b iso=%b want 1 0", slv_aw_ready_o, isolated_o);
        end
        slv_aw_valid_i = 0;
        do_reset();
        isolate_req_i = 1;
        tick(); tick();
        isolate_req_i = 0;
        tick();
        slv_aw_valid_i = 1;
        #2;
        n_checks++;
        if (isolated_o !== 1'b0 || slv_aw_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL release: iso=%b ready=%b want 0 1", isolated_o, slv_aw_ready_o);
        end
        slv_aw_valid_i = 0;
    endtask

    task automatic test_error_reset();
        do_reset();
        mst_b_valid_i = 1;
        tick();
        mst_b_valid_i = 0;
        #2;
        n_checks++;
        if (err_o !== 1'b1 || wr_cnt_o !== CW'(0)) begin
            n_errors++;
            $display("FAIL err_b_underflow: err=%b wr=%0d want 1 0", err_o, wr_cnt_o);
        end
        do_reset();
        mst_r_valid_i = 1; mst_r_last_i = 1;
        tick();
        mst_r_valid_i = 0; mst_r_last_i = 0;
        #2;
        n_checks++;
        if (err_o !== 1'b1 || rd_cnt_o !== CW'(0)) begin
            n_errors++;
            $display("FAIL err_r_underflow: err=%b rd=%0d want 1 0", err_o, rd_cnt_o);
        end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            slv_aw_valid_i = (i < 4);
            slv_ar_valid_i = 1;
            tick();
        end
        slv_aw_valid_i = 0; slv_ar_valid_i = 0;
        isolate_req_i = 1;
        tick();
        #2;
        n_checks++;
        if (wr_cnt_o !== CW'(4) || rd_cnt_o !== CW'(5) || isolated_o !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_setup: wr=%0d rd=%0d iso=%b want 4 5 0", wr_cnt_o, rd_cnt_o, isolated_o);
        end
        rst_ni = 0;
        tick();
        rst_ni = 1;
        slv_aw_valid_i = 1;
        #2;
        n_checks++;
        if ({isolated_o, busy_o, err_o, wr_cnt_o, rd_cnt_o} !== '0 || mst_aw_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid_drain: iso=%b busy=%b err=%b wr=%0d rd=%0d mst_valid=%b want 0 0 0 0 0 1",
                     isolated_o, busy_o, err_o, wr_cnt_o, rd_cnt_o, mst_aw_valid_o);
        end
        slv_aw_valid_i = 0; isolate_req_i = 0;
        tick();
    endtask

    task automatic test_random();
        logic [3:0]        exp_gate, got_gate;
        logic [3+2*CW-1:0] exp_stat, got_stat;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            // Phase 1 only returns responses that match outstanding traffic;
            // phase 2 lets stray responses through to exercise err_o.
            bit legal_only = (c < 3000);
            rst_ni = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 29) == 0) isolate_req_i = ~isolate_req_i;
            slv_aw_valid_i = $urandom_range(0, 1);
            mst_aw_ready_i = ($urandom_range(0, 3) != 0);
            slv_ar_valid_i = $urandom_range(0, 1);
            mst_ar_ready_i = ($urandom_range(0, 3) != 0);
            slv_b_ready_i  = ($urandom_range(0, 3) != 0);
            slv_r_ready_i  = ($urandom_range(0, 3) != 0);
            mst_r_last_i   = $urandom_range(0, 1);
            mst_b_valid_i  = ($urandom_range(0, 2) == 0) && (!legal_only || m_wr > 0);
            mst_r_valid_i  = ($urandom_range(0, 1) == 0) && (!legal_only || m_rd > 0);
            #2;
            exp_gate = {slv_aw_valid_i && mdl_aw_open(), mst_aw_ready_i && mdl_aw_open(),
                        slv_ar_valid_i && mdl_ar_open(), mst_ar_ready_i && mdl_ar_open()};
            got_gate = {mst_aw_valid_o, slv_aw_ready_o, mst_ar_valid_o, slv_ar_ready_o};
            n_checks++;
            if (got_gate !== exp_gate) begin
                n_errors++;
                $display("FAIL rand_gate cyc %0d: got %b want %b", c, got_gate, exp_gate);
            end
            exp_stat = {m_mode == 2, (m_wr != 0) || (m_rd != 0), m_err, CW'(m_wr), CW'(m_rd)};
            got_stat = {isolated_o, busy_o, err_o, wr_cnt_o, rd_cnt_o};
            n_checks++;
            if (got_stat !== exp_stat) begin
                n_errors++;
                $display("FAIL rand_status cyc %0d: got %h want %h", c, got_stat, exp_stat);
            end
            tick();
        end
        rst_ni = 1; isolate_req_i = 0; quiet_inputs();
    endtask

    initial begin
        m_wr = 0; m_rd = 0; m_mode = 0; m_err = 0;
        m_aw_pending = 0; m_ar_pending = 0;
        test_reset();
        test_throttle();
        test_drain();
        test_hold();
        test_simultaneous();
        test_abort_release();
        test_error_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
